evm_v3: RTL and testbench

//  Four-candidate electronic voting machine core: counts one-hot button votes in

---
 rtl/evm_v3.sv | 114 +++++++++++
 tb/tb_evm_v3.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_v3.sv
// Four-candidate voting machine core: edge-detected one-hot votes, saturating tallies.
// Optional TOTAL_DISPLAY_EN adds a total-votes counter shown for buttons 4'b1111.
module evm_v3 #(
    parameter int CNT_W    = 8,
    parameter int NUM_CAND = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] candid_button,
    output logic [NUM_CAND-1:0] vot_logged,
    output logic                valid_vote,
    output logic                invalid_vote,
    output logic [CNT_W-1:0]    display_out
);

    logic [NUM_CAND-1:0] btn_q, btn_prev_q;
    logic                mode_q;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND];
    logic [CNT_W-1:0]    cnt_d [NUM_CAND];
    logic [NUM_CAND-1:0] vot_q, vot_d;
    logic                valid_q, valid_d;
    logic                invalid_q, invalid_d;
    logic [CNT_W-1:0]    disp_q, disp_d;
`ifdef TOTAL_DISPLAY_EN
    logic [CNT_W-1:0]    total_q, total_d;
`endif

    logic                press;
    logic                one_hot;
    logic [CNT_W-1:0]    sel_cnt;

    assign press   = (btn_q != btn_prev_q) && (btn_q != '0);
    assign one_hot = (btn_q != '0) &&
                     ((btn_q & (btn_q - NUM_CAND'(1))) == '0);

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (btn_q[i]) sel_cnt = cnt_q[i];
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        vot_d     = vot_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        disp_d    = '0;
        if (!mode_q) begin
            if (press) begin
                if (one_hot) begin
                    valid_d = 1'b1;
                    vot_d   = btn_q;
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (btn_q[i] && cnt_q[i] != '1)
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    invalid_d = 1'b1;
                end
            end
        end else begin
            // Result mode: counters frozen, only the display is refreshed
            if (one_hot) begin
                disp_d = sel_cnt;
`ifdef TOTAL_DISPLAY_EN
            end else if (btn_q == '1) begin
                disp_d = total_q;
`endif
            end
        end
    end

`ifdef TOTAL_DISPLAY_EN
    always_comb begin
        total_d = total_q;
        if (valid_d && total_q != '1) total_d = total_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) total_q <= '0;
        else       total_q <= total_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q      <= '0;
            btn_prev_q <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= '{default: '0};
            vot_q      <= '0;
            valid_q    <= 1'b0;
            invalid_q  <= 1'b0;
            disp_q     <= '0;
        end else begin
            btn_q      <= candid_button;
            btn_prev_q <= btn_q;
            mode_q     <= mode;
            cnt_q      <= cnt_d;
            vot_q      <= vot_d;
            valid_q    <= valid_d;
            invalid_q  <= invalid_d;
            disp_q     <= disp_d;
        end
    end

    assign vot_logged   = vot_q;
    assign valid_vote   = valid_q;
    assign invalid_vote = invalid_q;
    assign display_out  = disp_q;

endmodule

// File: tb/tb_evm_v3.sv
// Self-checking bench for evm_v3: directed tables, corner sequences, random vs model.
module tb_evm_v3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode = 1'b0;
    logic [3:0] candid_button = 4'b0000;
    logic [3:0] vot_logged;
    logic       valid_vote;
    logic       invalid_vote;
    logic [7:0] display_out;

    evm_v3 dut (
        .clk(clk), .reset(reset), .mode(mode),
        .candid_button(candid_button), .vot_logged(vot_logged),
        .valid_vote(valid_vote), .invalid_vote(invalid_vote),
        .display_out(display_out)
    );

    always #5 clk = ~clk;

`ifdef TOTAL_DISPLAY_EN
    localparam bit TOT = 1'b1;
`else
    localparam bit TOT = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: tallies and the history of sampled inputs
    int         tally [4];
    int         total;
    logic [3:0] hist [$];
    logic       mhist [$];
    logic [3:0] e_vot;
    logic       e_valid, e_inval;
    int         e_disp;
    int         n_valid, n_inval;

    typedef struct {
        logic [3:0] btn;
        logic       v;
        logic       iv;
    } vvec_t;

    typedef struct {
        logic [3:0] btn;
        int         disp;
    } rvec_t;

    vvec_t s2 [20];
    rvec_t rt [7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) tally[i] = 0;
        total = 0;
        hist.delete();
        mhist.delete();
        hist.push_back(4'b0000);
        hist.push_back(4'b0000);
        mhist.push_back(1'b0);
        e_vot = 4'b0000;
        e_valid = 1'b0;
        e_inval = 1'b0;
        e_disp = 0;
    endtask

    // One clock edge: outputs follow from the sample taken one edge earlier
    task automatic model_edge(input logic [3:0] nb, input logic nm);
        logic [3:0] b, p;
        logic m;
        int idx;
        b = hist[hist.size()-1];
        p = hist[hist.size()-2];
        m = mhist[mhist.size()-1];
        idx = 0;
        for (int i = 0; i < 4; i++) if (b[i]) idx = i;
        e_valid = 1'b0;
        e_inval = 1'b0;
        e_disp = 0;
        if (!m) begin
            if (b != p && b != 0) begin
                if ($countones(b) == 1) begin
                    e_valid = 1'b1;
                    e_vot = b;
                    if (tally[idx] < 255) tally[idx]++;
                    if (total < 255) total++;
                end else begin
                    e_inval = 1'b1;
                end
            end
        end else begin
            if ($countones(b) == 1) e_disp = tally[idx];
            else if (b == 4'b1111 && TOT) e_disp = total;
        end
        hist.push_back(nb);
        mhist.push_back(nm);
        if (hist.size() > 4) void'(hist.pop_front());
        if (mhist.size() > 4) void'(mhist.pop_front());
    endtask

    task automatic tick(input logic [3:0] b, input logic m);
        candid_button = b;
        mode = m;
        @(posedge clk);
        model_edge(b, m);
        #1;
        chk("vot_logged", 32'(vot_logged), 32'(e_vot));
        chk("valid_vote", 32'(valid_vote), 32'(e_valid));
        chk("invalid_vote", 32'(invalid_vote), 32'(e_inval));
        chk("display_out", 32'(display_out), 32'(e_disp));
        if (valid_vote) n_valid++;
        if (invalid_vote) n_inval++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vot"}, 32'(vot_logged), 0);
        chk({tag, "_valid"}, 32'(valid_vote), 0);
        chk({tag, "_invalid"}, 32'(invalid_vote), 0);
        chk({tag, "_disp"}, 32'(display_out), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        candid_button = 4'b0000;
        mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        s2 = '{'{4'b0001,1,0}, '{4'b0010,1,0}, '{4'b1000,1,0},
               '{4'b0100,1,0}, '{4'b0000,0,0}, '{4'b0010,1,0},
               '{4'b1000,1,0}, '{4'b0100,1,0}, '{4'b0000,0,0},
               '{4'b0001,1,0}, '{4'b0101,0,1}, '{4'b0001,1,0},
               '{4'b0010,1,0}, '{4'b0001,1,0}, '{4'b0101,0,1},
               '{4'b0100,1,0}, '{4'b1000,1,0}, '{4'b0111,0,1},
               '{4'b0000,0,0}, '{4'b0001,1,0}};
        rt = '{'{4'b0001,5}, '{4'b0010,3}, '{4'b0100,3},
               '{4'b1000,3}, '{4'b1001,0}, '{4'b0000,0},
               '{4'b1111, TOT ? 14 : 0}};
        model_reset();

        // Reset, then four single votes
        do_reset();
        n_valid = 0;
        begin
            logic [3:0] seq1 [4];
            seq1 = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
            for (int k = 0; k < 4; k++) begin
                tick(seq1[k], 1'b0);
                tick(seq1[k], 1'b0);
                chk("s1_vot_follow", 32'(vot_logged), 32'(seq1[k]));
            end
        end
        chk("s1_valid_pulses", n_valid, 4);

        // Mixed voting sequence with invalid presses
        do_reset();
        n_valid = 0;
        n_inval = 0;
        for (int k = 0; k < 20; k++) begin
            tick(s2[k].btn, 1'b0);
            tick(s2[k].btn, 1'b0);
            chk("s2_valid", 32'(valid_vote), 32'(s2[k].v));
            chk("s2_invalid", 32'(invalid_vote), 32'(s2[k].iv));
        end
        chk("s2_valid_pulses", n_valid, 14);
        chk("s2_invalid_pulses", n_inval, 3);

        // Result mode display table
        n_valid = 0;
        n_inval = 0;
        for (int k = 0; k < 7; k++) begin
            tick(rt[k].btn, 1'b1);
            tick(rt[k].btn, 1'b1);
            chk("s3_display", 32'(display_out), 32'(rt[k].disp));
        end
        chk("s3_no_pulses", n_valid + n_inval, 0);

        // Held button counts once; direct change to another counts again
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        n_valid = 0;
        repeat (10) tick(4'b0001, 1'b0);
        chk("s4_hold_pulses", n_valid, 1);
        tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b0);
        chk("s4_change_pulses", n_valid, 2);
        tick(4'b0001, 1'b1);
        tick(4'b0001, 1'b1);
        chk("s4_c0", 32'(display_out), 6);
        tick(4'b0010, 1'b1);
        tick(4'b0010, 1'b1);
        chk("s4_c1", 32'(display_out), 4);

        // Saturation, then asynchronous reset mid-operation
        do_reset();
        repeat (260) begin
            tick(4'b0001, 1'b0);
            tick(4'b0000, 1'b0);
        end
        tick(4'b0001, 1'b1);
        tick(4'b0001, 1'b1);
        chk("s5_saturate", 32'(display_out), 255);
        async_reset();
        tick(4'b0001, 1'b1);
        tick(4'b0001, 1'b1);
        chk("s5_after_reset", 32'(display_out), 0);

        // Random traffic against the model
        begin
            logic m;
            logic [3:0] b;
            m = 1'b0;
            for (int k = 0; k < 800; k++) begin
                if ($urandom_range(15) == 0) m = ~m;
                case ($urandom_range(3))
                    0: b = 4'b0000;
                    1: b = 4'(1 << $urandom_range(3));
                    default: b = 4'($urandom_range(15));
                endcase
                if ($urandom_range(199) == 0) do_reset();
                tick(b, m);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
